// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the core MEM stage and a secondary
// bus master, sequencing multi-cycle reads and stalling the core while it waits.
module dmem_port_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic [3:0]  c_en,
  input  logic        c_wea,
  input  logic        c_rea,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_din,
  output logic [31:0] c_dout,
  output logic        mem_hold,
  input  logic        p_req,
  input  logic        p_we,
  input  logic [3:0]  p_be,
  input  logic [31:0] p_addr,
  input  logic [31:0] p_din,
  output logic [31:0] p_dout,
  output logic        p_ack,
  output logic [3:0]  m_en,
  output logic        m_wea,
  output logic [31:0] m_addr,
  output logic [31:0] m_din,
  input  logic [31:0] m_dout
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam int LC_W = 2;
  localparam logic [LC_W-1:0] LAT_INIT   = LC_W'(RD_LAT - 1);
  localparam logic [SC_W-1:0] STARVE_TOP = SC_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CORE_RD = 2'd1,
    PER_RD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic [LC_W-1:0]   lat_q, lat_d;
  logic [31:0]       c_dout_q, c_dout_d;
  logic [31:0]       p_dout_q, p_dout_d;

  logic c_req;
  logic per_win;
  logic core_win;
  logic core_done;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d   = state_q;
    starve_d  = starve_q;
    lat_d     = lat_q;
    c_dout_d  = c_dout_q;
    p_dout_d  = p_dout_q;
    m_en      = '0;
    m_wea     = 1'b0;
    m_addr    = c_addr;
    m_din     = c_din;
    p_ack     = 1'b0;
    core_done = 1'b0;

    c_req    = (|c_en) & (c_wea | c_rea);
    per_win  = (state_q == IDLE) & p_req & (~c_req | (starve_q == STARVE_TOP));
    core_win = (state_q == IDLE) & c_req & ~per_win;

    case (state_q)
      IDLE: begin
        if (per_win) begin
          m_en   = p_be;
          m_wea  = p_we & (|p_be);
          m_addr = p_addr;
          m_din  = p_din;
          // A zero byte-enable read has nothing to wait for, so it acks immediately.
          if (p_we || (p_be == 4'h0)) begin
            p_ack = 1'b1;
          end else begin
            state_d = PER_RD;
            lat_d   = LAT_INIT;
          end
        end else if (core_win) begin
          m_en  = c_en;
          m_wea = c_wea;
          if (c_wea) begin
            core_done = 1'b1;
          end else begin
            state_d = CORE_RD;
            lat_d   = LAT_INIT;
          end
        end
      end
      CORE_RD: begin
        if (lat_q == '0) begin
          core_done = 1'b1;
          c_dout_d  = m_dout;
          state_d   = IDLE;
        end else begin
          lat_d = lat_q - LC_W'(1);
        end
      end
      PER_RD: begin
        if (lat_q == '0) begin
          p_ack    = 1'b1;
          p_dout_d = m_dout;
          state_d  = IDLE;
        end else begin
          lat_d = lat_q - LC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The peripheral owns the port while PER_RD runs, so those cycles are not counted as denials.
    if (per_win) begin
      starve_d = '0;
    end else if (p_req && (state_q != PER_RD) && (starve_q != STARVE_TOP)) begin
      starve_d = starve_q + SC_W'(1);
    end

    if (!Rst_n) begin
      m_en      = '0;
      m_wea     = 1'b0;
      p_ack     = 1'b0;
      core_done = 1'b0;
      c_dout_d  = c_dout_q;
      p_dout_d  = p_dout_q;
    end

    mem_hold = Rst_n & c_req & ~core_done;
  end

  // Read data is forwarded in the completion cycle and then held by the register.
  assign c_dout = c_dout_d;
  assign p_dout = p_dout_d;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!Rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      lat_q    <= '0;
      c_dout_q <= '0;
      p_dout_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      lat_q    <= lat_d;
      c_dout_q <= c_dout_d;
      p_dout_q <= p_dout_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: grant-cycle vector table plus hand-written
// multi-cycle sequences, with read data checked through a scoreboard queue.
module tb_dmem_port_arbiter;

  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        Rst_n;
  logic [3:0]  c_en;
  logic        c_wea, c_rea;
  logic [31:0] c_addr, c_din, c_dout;
  logic        mem_hold;
  logic        p_req, p_we;
  logic [3:0]  p_be;
  logic [31:0] p_addr, p_din, p_dout;
  logic        p_ack;
  logic [3:0]  m_en;
  logic        m_wea;
  logic [31:0] m_addr, m_din, m_dout;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .Rst_n(Rst_n),
    .c_en(c_en), .c_wea(c_wea), .c_rea(c_rea), .c_addr(c_addr), .c_din(c_din),
    .c_dout(c_dout), .mem_hold(mem_hold),
    .p_req(p_req), .p_we(p_we), .p_be(p_be), .p_addr(p_addr), .p_din(p_din),
    .p_dout(p_dout), .p_ack(p_ack),
    .m_en(m_en), .m_wea(m_wea), .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout)
  );

  // Behavioural BRAM: data appears RD_LAT cycles after the address is issued.
  logic [31:0] mem [0:255];
  logic [31:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (m_wea && m_en[b]) mem[m_addr[9:2]][8*b +: 8] <= m_din[8*b +: 8];
    rd_pipe[0] <= mem[m_addr[9:2]];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign m_dout = rd_pipe[RD_LAT-1];

  logic [31:0] ref_mem [0:255];
  logic [31:0] sb_q [$];
  logic [31:0] exp_pdout;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  c_en;
    logic        c_wea, c_rea;
    logic [31:0] c_addr, c_din;
    logic        p_req, p_we;
    logic [3:0]  p_be;
    logic [31:0] p_addr, p_din;
    logic [3:0]  e_m_en;
    logic        e_m_wea, e_hold, e_ack;
    logic [31:0] e_addr, e_din;
  } vec_t;
  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_pop_check(input string name, input logic [31:0] act);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h", name, act);
    end else begin
      check(name, act, sb_q.pop_front());
    end
  endtask

  task automatic ref_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] din);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[addr[9:2]][8*b +: 8] = din[8*b +: 8];
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic core_idle();
    c_en = 4'h0; c_wea = 1'b0; c_rea = 1'b0; c_addr = '0; c_din = '0;
  endtask

  task automatic per_idle();
    p_req = 1'b0; p_we = 1'b0; p_be = 4'h0; p_addr = '0; p_din = '0;
  endtask

  task automatic do_reset();
    core_idle();
    per_idle();
    Rst_n = 1'b0;
    next_cycle();
    next_cycle();
    Rst_n = 1'b1;
    exp_pdout = '0;
  endtask

  task automatic core_write(input logic [31:0] addr, input logic [31:0] din, input string name);
    c_en = 4'hF; c_wea = 1'b1; c_rea = 1'b0; c_addr = addr; c_din = din;
    @(negedge clk);
    check({name, "_m_wea"}, 32'(m_wea), 32'd1);
    check({name, "_hold"}, 32'(mem_hold), 32'd0);
    ref_write(addr, 4'hF, din);
    next_cycle();
    core_idle();
  endtask

  task automatic core_read(input logic [31:0] addr, input string name);
    int k;
    bit done;
    logic [31:0] e;
    c_en = 4'hF; c_wea = 1'b0; c_rea = 1'b1; c_addr = addr;
    e = ref_mem[addr[9:2]];
    sb_q.push_back(e);
    k = 0;
    done = 1'b0;
    while (!done && k < 20) begin
      @(negedge clk);
      if (!mem_hold) done = 1'b1;
      else begin
        next_cycle();
        k++;
      end
    end
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_hold_cycles"}, k, RD_LAT);
    sb_pop_check({name, "_c_dout"}, c_dout);
    next_cycle();
    core_idle();
    @(negedge clk);
    check({name, "_c_dout_held"}, c_dout, e);
    next_cycle();
  endtask

  task automatic per_access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] din, input int exp_lat, input string name);
    int k;
    bit got;
    p_req = 1'b1; p_we = we; p_be = be; p_addr = addr; p_din = din;
    if (!we) begin
      if (be != 4'h0) exp_pdout = ref_mem[addr[9:2]];
      sb_q.push_back(exp_pdout);
    end
    k = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      if (p_ack) got = 1'b1;
      else begin
        next_cycle();
        k++;
      end
    end
    check({name, "_acked"}, 32'(got), 32'd1);
    check({name, "_ack_cycle"}, k, exp_lat);
    if (!we) sb_pop_check({name, "_p_dout"}, p_dout);
    else ref_write(addr, be, din);
    next_cycle();
    per_idle();
    @(negedge clk);
    check({name, "_ack_single"}, 32'(p_ack), 32'd0);
    if (!we) check({name, "_p_dout_held"}, p_dout, exp_pdout);
    next_cycle();
  endtask

  initial begin
    int k, core_k, ack_k;

    vecs[0]  = '{4'hF, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,
                 4'hF, 1'b1, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF};
    vecs[1]  = '{4'hF, 1'b0, 1'b1, 32'h104, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,  32'h0,
                 4'hF, 1'b0, 1'b1, 1'b0, 32'h104, 32'h0};
    vecs[2]  = '{4'h3, 1'b1, 1'b1, 32'h108, 32'h11223344, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,
                 4'h3, 1'b1, 1'b0, 1'b0, 32'h108, 32'h11223344};
    vecs[3]  = '{4'h0, 1'b1, 1'b0, 32'h10C, 32'h0000FFFF, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,
                 4'h0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0};
    vecs[4]  = '{4'h0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 4'hF, 32'h80, 32'hA0A0A0A0,
                 4'hF, 1'b1, 1'b0, 1'b1, 32'h80,  32'hA0A0A0A0};
    vecs[5]  = '{4'h0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 4'hF, 32'h84, 32'h0,
                 4'hF, 1'b0, 1'b0, 1'b0, 32'h84,  32'h0};
    vecs[6]  = '{4'h0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 4'h0, 32'h84, 32'h0,
                 4'h0, 1'b0, 1'b0, 1'b1, 32'h0,   32'h0};
    vecs[7]  = '{4'hF, 1'b0, 1'b1, 32'h100, 32'h0,        1'b1, 1'b1, 4'hF, 32'h88, 32'h55,
                 4'hF, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0};
    vecs[8]  = '{4'hC, 1'b1, 1'b0, 32'h10C, 32'h99887766, 1'b1, 1'b1, 4'hF, 32'h8C, 32'h66,
                 4'hC, 1'b1, 1'b0, 1'b0, 32'h10C, 32'h99887766};
    vecs[9]  = '{4'h0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 4'h0, 32'h0,  32'h0,
                 4'h0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0};
    vecs[10] = '{4'h0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 4'h5, 32'h90, 32'h01020304,
                 4'h5, 1'b1, 1'b0, 1'b1, 32'h90,  32'h01020304};

    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    exp_pdout = '0;

    // Reset with live requests: memory strobes, stall and ack stay low, registers clear.
    Rst_n = 1'b0;
    c_en = 4'hF; c_wea = 1'b0; c_rea = 1'b1; c_addr = 32'h100; c_din = '0;
    p_req = 1'b1; p_we = 1'b1; p_be = 4'hF; p_addr = 32'h80; p_din = 32'h1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_m_en", 32'(m_en), 32'd0);
    check("rst_m_wea", 32'(m_wea), 32'd0);
    check("rst_hold", 32'(mem_hold), 32'd0);
    check("rst_p_ack", 32'(p_ack), 32'd0);
    check("rst_c_dout", c_dout, 32'd0);
    check("rst_p_dout", p_dout, 32'd0);
    next_cycle();

    // Grant-cycle table, each vector applied from a freshly reset IDLE state.
    for (int i = 0; i < 11; i++) begin
      core_idle();
      per_idle();
      Rst_n = 1'b0;
      next_cycle();
      Rst_n = 1'b1;
      c_en = vecs[i].c_en; c_wea = vecs[i].c_wea; c_rea = vecs[i].c_rea;
      c_addr = vecs[i].c_addr; c_din = vecs[i].c_din;
      p_req = vecs[i].p_req; p_we = vecs[i].p_we; p_be = vecs[i].p_be;
      p_addr = vecs[i].p_addr; p_din = vecs[i].p_din;
      @(negedge clk);
      check($sformatf("vec%0d_m_en", i), 32'(m_en), 32'(vecs[i].e_m_en));
      check($sformatf("vec%0d_m_wea", i), 32'(m_wea), 32'(vecs[i].e_m_wea));
      check($sformatf("vec%0d_hold", i), 32'(mem_hold), 32'(vecs[i].e_hold));
      check($sformatf("vec%0d_p_ack", i), 32'(p_ack), 32'(vecs[i].e_ack));
      if (vecs[i].e_m_en != 4'h0) check($sformatf("vec%0d_m_addr", i), m_addr, vecs[i].e_addr);
      if (vecs[i].e_m_wea) begin
        check($sformatf("vec%0d_m_din", i), m_din, vecs[i].e_din);
        ref_write(vecs[i].e_addr, vecs[i].e_m_en, vecs[i].e_din);
      end
      next_cycle();
    end

    // Core write then read-back: stall for RD_LAT cycles, data in the release cycle.
    do_reset();
    core_write(32'h100, 32'hDEADBEEF, "t1_wr");
    core_read(32'h100, "t2_rd");

    // Core read and peripheral write together: core first, peripheral acked afterwards.
    c_en = 4'hF; c_wea = 1'b0; c_rea = 1'b1; c_addr = 32'h100;
    p_req = 1'b1; p_we = 1'b1; p_be = 4'hF; p_addr = 32'h44; p_din = 32'hA5A50044;
    sb_q.push_back(ref_mem[32'h100 >> 2]);
    core_k = -1;
    ack_k = -1;
    k = 0;
    while (ack_k < 0 && k < 20) begin
      @(negedge clk);
      if (p_ack) ack_k = k;
      if (core_k < 0 && !mem_hold) begin
        core_k = k;
        sb_pop_check("t3_c_dout", c_dout);
      end
      next_cycle();
      if (core_k >= 0) core_idle();
      k++;
    end
    per_idle();
    check("t3_core_lat", core_k, RD_LAT);
    check("t3_ack_cycle", ack_k, RD_LAT + 1);
    ref_write(32'h44, 4'hF, 32'hA5A50044);
    core_read(32'h44, "t3_rb");

    // Starvation: back-to-back core writes, peripheral wins after STARVE_MAX denials.
    do_reset();
    p_req = 1'b1; p_we = 1'b1; p_be = 4'hF; p_addr = 32'h48; p_din = 32'hCAFE0048;
    c_en = 4'hF; c_wea = 1'b1; c_rea = 1'b0; c_addr = 32'h200; c_din = 32'h0;
    ack_k = -1;
    k = 0;
    while (ack_k < 0 && k < 20) begin
      @(negedge clk);
      if (p_ack) begin
        ack_k = k;
        check("t4_core_held", 32'(mem_hold), 32'd1);
      end else begin
        check($sformatf("t4_core_free_%0d", k), 32'(mem_hold), 32'd0);
      end
      next_cycle();
      if (ack_k < 0) begin
        c_addr = c_addr + 32'd4;
        c_din  = c_din + 32'd1;
      end
      k++;
    end
    per_idle();
    check("t4_ack_cycle", ack_k, STARVE_MAX);
    @(negedge clk);
    check("t4_core_resume", 32'(mem_hold), 32'd0);
    next_cycle();
    core_idle();
    ref_write(32'h48, 4'hF, 32'hCAFE0048);
    core_read(32'h48, "t4_rb");

    // Peripheral read with full and with zero byte enables.
    core_write(32'h40, 32'h12345678, "t5_wr");
    per_access(1'b0, 4'hF, 32'h40, 32'h0, RD_LAT, "t5_rd");
    per_access(1'b0, 4'h0, 32'h40, 32'h0, 0, "t5_noop");

    // Reset during CORE_RD abandons the read and clears the data registers.
    c_en = 4'hF; c_wea = 1'b0; c_rea = 1'b1; c_addr = 32'h100;
    next_cycle();
    Rst_n = 1'b0;
    @(negedge clk);
    check("t6_hold_in_reset", 32'(mem_hold), 32'd0);
    check("t6_m_en_in_reset", 32'(m_en), 32'd0);
    next_cycle();
    Rst_n = 1'b1;
    core_idle();
    exp_pdout = '0;
    for (int i = 0; i <= RD_LAT; i++) begin
      @(negedge clk);
      check($sformatf("t6_c_dout_%0d", i), c_dout, 32'd0);
      check($sformatf("t6_p_dout_%0d", i), p_dout, 32'd0);
      check($sformatf("t6_hold_%0d", i), 32'(mem_hold), 32'd0);
      check($sformatf("t6_p_ack_%0d", i), 32'(p_ack), 32'd0);
      next_cycle();
    end
    core_read(32'h100, "t6_recover");

    check("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
